// File: rtl/pwm_fader_pkg.sv
// Shared constants for the PWM fader: default geometry, backlight level
// and where the HPS gp_out word carries the backlight request.
package pwm_fader_pkg;

    localparam int PWM_MAX_VALUE     = 1000;
    localparam int PWM_BITS          = 10;
    localparam int PWM_SCALE         = 250;
    localparam int PWM_SCALE_BITS    = 8;
    localparam int PWM_RAMP_STEP     = 8;
    localparam int BACKLIGHT_DEFAULT = 1000;

    localparam int GP_VALID_BIT = 1;
    localparam int GP_VALUE_LSB = 2;
    localparam int GP_VALUE_MSB = 11;

endpackage

// File: rtl/pwm_fader_channel.sv
// One PWM output: clamps the request, ramps the active duty once per
// period and compares it against the shared phase.
module pwm_fader_channel
    import pwm_fader_pkg::*;
#(
    parameter int MAX_VALUE     = PWM_MAX_VALUE,
    parameter int BITS          = PWM_BITS,
    parameter int RAMP_STEP     = PWM_RAMP_STEP,
    parameter int DEFAULT_VALUE = BACKLIGHT_DEFAULT
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [BITS-1:0] phase,
    input  logic            wrap,
    input  logic            ramp_enable,
    input  logic [BITS-1:0] target,
    input  logic            target_valid,
    output logic            signal,
    output logic [BITS-1:0] current,
    output logic            settled
);

    localparam logic [BITS:0]   MAX_W  = (BITS+1)'(MAX_VALUE);
    localparam logic [BITS:0]   STEP_W = (BITS+1)'(RAMP_STEP);
    localparam logic [BITS-1:0] MAX_B  = BITS'(MAX_VALUE);
    localparam logic [BITS-1:0] STEP_B = BITS'(RAMP_STEP);
    localparam logic [BITS-1:0] DEF_B  = BITS'(DEFAULT_VALUE);

    logic [BITS-1:0] eff;
    logic [BITS-1:0] nxt;
    logic [BITS:0]   diff;
    logic            up;

    // Out-of-range requests saturate rather than wrap.
    always_comb begin
        eff = DEF_B;
        if (target_valid) begin
            eff = ({1'b0, target} > MAX_W) ? MAX_B : target;
        end
    end

    assign up   = eff > current;
    assign diff = up ? ({1'b0, eff} - {1'b0, current})
                     : ({1'b0, current} - {1'b0, eff});

    // A full step only happens when diff exceeds it, so no under/overflow.
    always_comb begin
        nxt = eff;
        if (ramp_enable && (diff > STEP_W)) begin
            nxt = up ? (current + STEP_B) : (current - STEP_B);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            current <= DEF_B;
            signal  <= 1'b0;
        end else begin
            if (wrap) begin
                current <= nxt;
            end
            signal <= (phase < current);
        end
    end

    assign settled = (current == eff);

endmodule

// File: rtl/pwm_fader.sv
// Multi-channel slew-limited PWM: shared prescaler and phase counter
// feeding one ramping comparator per output.
module pwm_fader
    import pwm_fader_pkg::*;
#(
    parameter int CHANNELS      = 2,
    parameter int MAX_VALUE     = PWM_MAX_VALUE,
    parameter int BITS          = PWM_BITS,
    parameter int SCALE         = PWM_SCALE,
    parameter int SCALE_BITS    = PWM_SCALE_BITS,
    parameter int RAMP_STEP     = PWM_RAMP_STEP,
    parameter int DEFAULT_VALUE = BACKLIGHT_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [CHANNELS*BITS-1:0] target,
    input  logic [CHANNELS-1:0]      target_valid,
    input  logic                     ramp_enable,
    output logic [CHANNELS-1:0]      signal,
    output logic [CHANNELS*BITS-1:0] current,
    output logic [CHANNELS-1:0]      settled,
    output logic                     period_start
);

    if ((2 ** BITS) <= MAX_VALUE) begin : g_bad_bits
        $error("BITS too narrow for MAX_VALUE");
    end
    if ((2 ** SCALE_BITS) < SCALE) begin : g_bad_scale
        $error("SCALE_BITS too narrow for SCALE");
    end
    if (RAMP_STEP < 1) begin : g_bad_step
        $error("RAMP_STEP must be at least 1");
    end
    if (DEFAULT_VALUE > MAX_VALUE) begin : g_bad_default
        $error("DEFAULT_VALUE exceeds MAX_VALUE");
    end

    localparam logic [SCALE_BITS-1:0] PRE_LAST   = SCALE_BITS'(SCALE - 1);
    localparam logic [BITS-1:0]       PHASE_LAST = BITS'(MAX_VALUE - 1);

    logic [SCALE_BITS-1:0] pre;
    logic [BITS-1:0]       phase;
    logic                  tick;
    logic                  wrap;

    assign tick = (pre == PRE_LAST);
    assign wrap = tick && (phase == PHASE_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre          <= '0;
            phase        <= '0;
            period_start <= 1'b0;
        end else begin
            pre <= tick ? '0 : (pre + 1'b1);
            if (tick) begin
                phase <= (phase == PHASE_LAST) ? '0 : (phase + 1'b1);
            end
            period_start <= wrap;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pwm_fader_channel #(
            .MAX_VALUE    (MAX_VALUE),
            .BITS         (BITS),
            .RAMP_STEP    (RAMP_STEP),
            .DEFAULT_VALUE(DEFAULT_VALUE)
        ) u_ch (
            .clock       (clock),
            .reset_n     (reset_n),
            .phase       (phase),
            .wrap        (wrap),
            .ramp_enable (ramp_enable),
            .target      (target[g*BITS +: BITS]),
            .target_valid(target_valid[g]),
            .signal      (signal[g]),
            .current     (current[g*BITS +: BITS]),
            .settled     (settled[g])
        );
    end

endmodule

// File: tb/tb_pwm_fader.sv
// Scoreboard bench for pwm_fader: per-period expectations queued by the
// stimulus, per-cycle waveform and wrap checks done by a monitor.
module tb_pwm_fader;

    localparam int CH     = 2;
    localparam int MAXV   = 10;
    localparam int BITS   = 4;
    localparam int SCALE  = 2;
    localparam int STEP   = 3;
    localparam int DEF    = 10;
    localparam int PERIOD = SCALE * MAXV;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic [7:0]   target = '0;
    logic [1:0]   target_valid = '0;
    logic         ramp_enable = 1'b0;
    logic [1:0]   signal;
    logic [7:0]   current;
    logic [1:0]   settled;
    logic         period_start;

    always #5 clock = ~clock;

    pwm_fader #(
        .CHANNELS     (CH),
        .MAX_VALUE    (MAXV),
        .BITS         (BITS),
        .SCALE        (SCALE),
        .SCALE_BITS   (1),
        .RAMP_STEP    (STEP),
        .DEFAULT_VALUE(DEF)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .target      (target),
        .target_valid(target_valid),
        .ramp_enable (ramp_enable),
        .signal      (signal),
        .current     (current),
        .settled     (settled),
        .period_start(period_start)
    );

    typedef struct packed {
        logic [3:0] cur1;
        logic [3:0] cur0;
        logic [1:0] stl;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   running = 1'b0;
    int   mon_pos = 0;
    int   win_cur[2];
    int   m_cur[2];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff_of(input int ch);
        int t;
        t = int'(target[ch*4 +: 4]);
        if (!target_valid[ch]) return DEF;
        return (t > MAXV) ? MAXV : t;
    endfunction

    function automatic int ramp_to(input int cur, input int e, input bit ramp);
        if (!ramp) return e;
        if (e > cur) return (e - cur <= STEP) ? e : cur + STEP;
        return (cur - e <= STEP) ? e : cur - STEP;
    endfunction

    // Monitor: within a period, cycle i (1-based) is high iff i <= SCALE*duty.
    initial begin
        rec_t r;
        forever begin
            @(negedge clock);
            if (running) begin
                mon_pos++;
                for (int c = 0; c < CH; c++) begin
                    check($sformatf("signal%0d pos%0d", c, mon_pos),
                          int'(signal[c]),
                          (mon_pos <= SCALE * win_cur[c]) ? 1 : 0);
                end
                if (mon_pos == PERIOD) begin
                    check("period_start at wrap", int'(period_start), 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wrap_without_expectation at %0t", $time);
                    end else begin
                        r = exp_q.pop_front();
                        check("current0 at wrap", int'(current[3:0]), int'(r.cur0));
                        check("current1 at wrap", int'(current[7:4]), int'(r.cur1));
                        check("settled at wrap", int'(settled), int'(r.stl));
                        win_cur[0] = int'(r.cur0);
                        win_cur[1] = int'(r.cur1);
                    end
                    mon_pos = 0;
                end else begin
                    check("period_start idle", int'(period_start), 0);
                    check("current0 hold", int'(current[3:0]), win_cur[0]);
                    check("current1 hold", int'(current[7:4]), win_cur[1]);
                    for (int c = 0; c < CH; c++) begin
                        check($sformatf("settled%0d", c), int'(settled[c]),
                              (win_cur[c] == eff_of(c)) ? 1 : 0);
                    end
                end
            end
        end
    end

    task automatic run_period(input int mid_at, input logic [7:0] mid_t,
                              input logic [1:0] mid_v, input logic mid_r,
                              input int abort_at);
        rec_t r;
        for (int i = 1; i <= PERIOD; i++) begin
            if (i == abort_at) return;
            if (i == mid_at) begin
                target       = mid_t;
                target_valid = mid_v;
                ramp_enable  = mid_r;
            end
            if (i == PERIOD) begin
                for (int c = 0; c < CH; c++) begin
                    m_cur[c] = ramp_to(m_cur[c], eff_of(c), ramp_enable);
                end
                r.cur0   = 4'(m_cur[0]);
                r.cur1   = 4'(m_cur[1]);
                r.stl[0] = (m_cur[0] == eff_of(0));
                r.stl[1] = (m_cur[1] == eff_of(1));
                exp_q.push_back(r);
            end
            @(negedge clock);
            #1;
        end
    endtask

    task automatic periods(input int n);
        repeat (n) run_period(0, 8'h00, 2'b00, 1'b0, 0);
    endtask

    task automatic do_reset(input int hold);
        running = 1'b0;
        reset_n = 1'b0;
        #1;
        check("reset signal", int'(signal), 0);
        check("reset current", int'(current), 8'hAA);
        check("reset period_start", int'(period_start), 0);
        check("reset settled0", int'(settled[0]), (eff_of(0) == DEF) ? 1 : 0);
        check("reset settled1", int'(settled[1]), (eff_of(1) == DEF) ? 1 : 0);
        repeat (hold) @(negedge clock);
        #1;
        check("reset held current", int'(current), 8'hAA);
        exp_q.delete();
        for (int c = 0; c < CH; c++) begin
            m_cur[c]   = DEF;
            win_cur[c] = DEF;
        end
        mon_pos = 0;
        reset_n = 1'b1;
        running = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int mid;
        #2;
        do_reset(3);
        periods(2);

        target = 8'h04; target_valid = 2'b01; ramp_enable = 1'b0;
        periods(2);

        target[3:0] = 4'd10;
        periods(1);
        target[3:0] = 4'd0; ramp_enable = 1'b1;
        periods(5);

        target[7:4] = 4'd15; target_valid[1] = 1'b1;
        periods(1);
        target[7:4] = 4'd3; target_valid[1] = 1'b0;
        periods(1);

        target[3:0] = 4'd4; ramp_enable = 1'b0;
        periods(1);
        run_period(11, {target[7:4], 4'd8}, target_valid, ramp_enable, 0);
        periods(1);

        target[3:0] = 4'd10;
        periods(1);
        target[3:0] = 4'd0; ramp_enable = 1'b1;
        periods(2);
        check("pre-reset current0", int'(current[3:0]), 4);
        run_period(0, 8'h00, 2'b00, 1'b0, 7);
        do_reset(2);
        periods(2);

        repeat (30) begin
            target       = 8'($urandom);
            target_valid = 2'($urandom);
            ramp_enable  = 1'($urandom);
            mid = $urandom_range(0, 19);
            run_period(mid, 8'($urandom), 2'($urandom), 1'($urandom), 0);
        end

        running = 1'b0;
        check("scoreboard drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
